line_clear_engine: RTL and testbench

// - Line-port master for the playfield matrix memory. Runs after a piece commit.
// - Reads rows through a line read port and detects full rows (all ones).
// - Compacts the surviving rows toward the bottom (row height_p-1) through the line write port.
// - Zero-fills the vacated top rows, then reports how many lines were cleared.

---
 rtl/line_clear_engine.sv | 162 ++++++++++++++++
 tb/tb_line_clear_engine.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/line_clear_engine.sv
// Line-clear engine: finds full rows, compacts surviving rows toward the bottom, zero-fills the top.
// Optional feature macro: LINE_CLEAR_SCORE_EN adds a saturating score_o accumulator.
module line_clear_engine #(
    parameter int width_p  = 16,
    parameter int height_p = 32
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          start_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic [$clog2(height_p+1)-1:0] lines_cleared_o,
    output logic [$clog2(height_p)-1:0]   read_line_addr_o,
    input  logic [width_p-1:0]            read_line_data_i,
    output logic [$clog2(height_p)-1:0]   write_addr_o,
    output logic [width_p-1:0]            write_data_o,
    output logic                          v_w_o,
`ifdef LINE_CLEAR_SCORE_EN
    output logic [15:0]                   score_o,
`endif
    input  logic                          mem_ready_i
);

    localparam int AW = $clog2(height_p);
    localparam int CW = $clog2(height_p + 1);
    localparam logic [AW-1:0] LAST_ROW = AW'(height_p - 1);

    typedef enum logic [1:0] {IDLE, COMPACT, FILL, DONE} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   r_q, r_d, w_q, w_d;
    logic [CW-1:0]   c_q, c_d, lines_q, lines_d;
    logic            v_w_s;
    logic [width_p-1:0] wdata_s;
    logic            row_full_s;

`ifdef LINE_CLEAR_SCORE_EN
    logic [15:0]     score_q, score_d;

    function automatic logic [15:0] score_add(input logic [15:0] s, input logic [CW-1:0] c);
        logic [3:0]  inc;
        logic [16:0] sum;
        if (c == CW'(0))      inc = 4'd0;
        else if (c == CW'(1)) inc = 4'd1;
        else if (c == CW'(2)) inc = 4'd3;
        else if (c == CW'(3)) inc = 4'd5;
        else                  inc = 4'd8;
        sum = {1'b0, s} + {13'd0, inc};
        if (sum[16]) return 16'hFFFF;
        else         return sum[15:0];
    endfunction
`endif

    // Next-state, pointer and write-port decode
    always_comb begin
        state_d    = state_q;
        r_d        = r_q;
        w_d        = w_q;
        c_d        = c_q;
        lines_d    = lines_q;
        v_w_s      = 1'b0;
        wdata_s    = '0;
        row_full_s = &read_line_data_i;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = COMPACT;
                    r_d     = LAST_ROW;
                    w_d     = LAST_ROW;
                    c_d     = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            COMPACT: begin
                if (mem_ready_i) begin
                    if (row_full_s) begin
                        c_d = c_q + CW'(1);
                    end else begin
                        if (w_q != r_q) begin
                            v_w_s   = 1'b1;
                            wdata_s = read_line_data_i;
                        end else begin
                            v_w_s = 1'b0;
                        end
                        // w stays >= r, so it only sits at 0 when nothing was cleared
                        w_d = (w_q != AW'(0)) ? w_q - AW'(1) : w_q;
                    end
                    if (r_q == AW'(0)) begin
                        state_d = (c_d != CW'(0)) ? FILL : DONE;
                    end else begin
                        r_d = r_q - AW'(1);
                    end
                end else begin
                    state_d = COMPACT;
                end
            end
            FILL: begin
                if (mem_ready_i) begin
                    v_w_s = 1'b1;
                    if (w_q == AW'(0)) begin
                        state_d = DONE;
                    end else begin
                        w_d = w_q - AW'(1);
                    end
                end else begin
                    state_d = FILL;
                end
            end
            DONE: begin
                lines_d = c_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef LINE_CLEAR_SCORE_EN
    // Score accumulates once per completed pass
    always_comb begin
        if (state_q == DONE) score_d = score_add(score_q, c_q);
        else                 score_d = score_q;
    end
`endif

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            r_q     <= LAST_ROW;
            w_q     <= LAST_ROW;
            c_q     <= '0;
            lines_q <= '0;
`ifdef LINE_CLEAR_SCORE_EN
            score_q <= 16'h0000;
`endif
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            w_q     <= w_d;
            c_q     <= c_d;
            lines_q <= lines_d;
`ifdef LINE_CLEAR_SCORE_EN
            score_q <= score_d;
`endif
        end
    end

    assign busy_o           = (state_q == COMPACT) || (state_q == FILL);
    assign done_o           = (state_q == DONE);
    assign lines_cleared_o  = lines_q;
    assign read_line_addr_o = r_q;
    assign write_addr_o     = w_q;
    assign write_data_o     = wdata_s;
    assign v_w_o            = v_w_s & ~reset_i;
`ifdef LINE_CLEAR_SCORE_EN
    assign score_o          = score_q;
`endif

endmodule

// File: tb/tb_line_clear_engine.sv
// Self-checking bench for line_clear_engine: list-based compaction model, per-cycle write-port checks.
module tb_line_clear_engine;

    logic        clk_i = 1'b0;
    logic        reset_i, start_i, mem_ready_i;
    logic        busy_o, done_o, v_w_o;
    logic [5:0]  lines_cleared_o;
    logic [4:0]  read_line_addr_o, write_addr_o;
    logic [15:0] read_line_data_i, write_data_o;
`ifdef LINE_CLEAR_SCORE_EN
    logic [15:0] score_o;
    int          score_exp = 0;
`endif

    logic [15:0] mem [32];
    logic [15:0] img [32];
    logic [15:0] exp_img [32];
    logic        load_req;
    logic [20:0] exp_q [$];
    int          c_exp, last_lines;
    int          n_checks = 0, n_pass = 0;

    line_clear_engine dut (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
        .lines_cleared_o(lines_cleared_o), .read_line_addr_o(read_line_addr_o),
        .read_line_data_i(read_line_data_i), .write_addr_o(write_addr_o),
        .write_data_o(write_data_o), .v_w_o(v_w_o),
`ifdef LINE_CLEAR_SCORE_EN
        .score_o(score_o),
`endif
        .mem_ready_i(mem_ready_i)
    );

    always #5 clk_i = ~clk_i;

    assign read_line_data_i = mem[read_line_addr_o];

    // Playfield memory: bench preload or DUT line writes
    always @(posedge clk_i) begin
        if (load_req) mem <= img;
        else if (v_w_o) mem[write_addr_o] <= write_data_o;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, expv);
    endtask

    // Per-cycle write-port comparison against the expected write trace
    task automatic cmp_cycle();
        logic [20:0] e;
        if (v_w_o) begin
            if (reset_i || !mem_ready_i) chk("write_gated", 32'd1, 32'd0);
            else if (exp_q.size() == 0) chk("write_unexpected", {27'd0, write_addr_o}, 32'hFFFF_FFFF);
            else begin
                e = exp_q.pop_front();
                chk("write_addr", {27'd0, write_addr_o}, {27'd0, e[20:16]});
                chk("write_data", {16'd0, write_data_o}, {16'd0, e[15:0]});
            end
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
        cmp_cycle();
        @(posedge clk_i);
        #1;
    endtask

    // Model: keep non-full rows bottom-up, drop full rows, zero the top c rows
    task automatic build_model();
        int dst;
        dst = 31;
        c_exp = 0;
        exp_q.delete();
        for (int src = 31; src >= 0; src--) begin
            if (img[src] == 16'hFFFF) c_exp++;
            else begin
                if (dst != src) exp_q.push_back({dst[4:0], img[src]});
                exp_img[dst] = img[src];
                dst--;
            end
        end
        for (int k = c_exp - 1; k >= 0; k--) begin
            exp_q.push_back({k[4:0], 16'h0000});
            exp_img[k] = 16'h0000;
        end
    endtask

    task automatic load_img();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    // mode 0: ready always high, 1: random stalls, 2: five-cycle stall burst
    task automatic run_pass(input int mode, input bit hold_start);
        int need, rdycnt, cyc, nbad;
        bit rdy;
        load_img();
        chk("lines_hold", {26'd0, lines_cleared_o}, last_lines);
        start_i = 1'b1;
        mem_ready_i = 1'b1;
        tick();
        start_i = hold_start;
        need = 32 + c_exp;
        rdycnt = 0;
        cyc = 0;
        while (rdycnt < need && cyc < 5000) begin
            case (mode)
                1:       rdy = ($urandom_range(0, 99) >= 25);
                2:       rdy = !(cyc >= 10 && cyc < 15);
                default: rdy = 1'b1;
            endcase
            mem_ready_i = rdy;
            chk("busy_in_pass", {31'd0, busy_o}, 32'd1);
            chk("done_early", {31'd0, done_o}, 32'd0);
            tick();
            if (rdy) rdycnt++;
            cyc++;
        end
        chk("no_timeout", {31'd0, cyc < 5000}, 32'd1);
        if (mode == 2) chk("stall_latency", cyc, need + 5);
        mem_ready_i = 1'b1;
        chk("done_pulse", {31'd0, done_o}, 32'd1);
        chk("busy_in_done", {31'd0, busy_o}, 32'd0);
        tick();
        start_i = 1'b0;
        chk("done_one_cycle", {31'd0, done_o}, 32'd0);
        chk("lines_cleared", {26'd0, lines_cleared_o}, c_exp);
        chk("trace_drained", exp_q.size(), 32'd0);
        nbad = 0;
        for (int i = 0; i < 32; i++) if (mem[i] !== exp_img[i]) nbad++;
        chk("mem_image", nbad, 32'd0);
`ifdef LINE_CLEAR_SCORE_EN
        score_exp = score_exp + ((c_exp == 0) ? 0 : (c_exp == 1) ? 1 : (c_exp == 2) ? 3 : (c_exp == 3) ? 5 : 8);
        if (score_exp > 65535) score_exp = 65535;
        chk("score", {16'd0, score_o}, score_exp);
`endif
        tick();
        chk("no_restart", {31'd0, busy_o}, 32'd0);
        last_lines = c_exp;
    endtask

    task automatic random_img();
        for (int i = 0; i < 32; i++) begin
            if ($urandom_range(0, 99) < 30) img[i] = 16'hFFFF;
            else begin
                img[i] = 16'($urandom);
                if (img[i] == 16'hFFFF) img[i] = 16'hFFFE;
            end
        end
    endtask

    initial begin
        reset_i = 1'b1;
        start_i = 1'b0;
        mem_ready_i = 1'b1;
        load_req = 1'b0;
        last_lines = 0;
        for (int i = 0; i < 32; i++) img[i] = 16'h0000;
        tick();
        tick();
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_vw", {31'd0, v_w_o}, 32'd0);
        chk("rst_lines", {26'd0, lines_cleared_o}, 32'd0);
        chk("rst_raddr", {27'd0, read_line_addr_o}, 32'd31);
        chk("rst_waddr", {27'd0, write_addr_o}, 32'd31);
        reset_i = 1'b0;

        // Empty board: no writes, done after 33 cycles
        build_model();
        chk("model_empty_c", c_exp, 32'd0);
        chk("model_empty_q", exp_q.size(), 32'd0);
        run_pass(0, 1'b0);

        // Bottom row full, two partial rows above
        for (int i = 0; i < 32; i++) img[i] = 16'h0000;
        img[31] = 16'hFFFF;
        img[30] = 16'h00F0;
        img[29] = 16'h00F0;
        build_model();
        chk("model_one_c", c_exp, 32'd1);
        chk("model_one_q", exp_q.size(), 32'd32);
        chk("model_one_first", {11'd0, exp_q[0]}, {11'd0, 5'd31, 16'h00F0});
        run_pass(0, 1'b0);

        // Four bottom rows full, held start through the pass
        for (int i = 0; i < 32; i++) img[i] = (i >= 28) ? 16'hFFFF : 16'h0000;
        build_model();
        chk("model_four_c", c_exp, 32'd4);
        chk("model_four_fill", {11'd0, exp_q[28]}, {11'd0, 5'd3, 16'h0000});
        run_pass(0, 1'b1);

        // Five-cycle stall burst mid-compaction
        random_img();
        build_model();
        run_pass(2, 1'b0);

        // All rows full
        for (int i = 0; i < 32; i++) img[i] = 16'hFFFF;
        build_model();
        chk("model_full_c", c_exp, 32'd32);
        chk("model_full_first", {11'd0, exp_q[0]}, {11'd0, 5'd31, 16'h0000});
        run_pass(0, 1'b0);

        // Randomized boards with random stalls
        for (int t = 0; t < 6; t++) begin
            random_img();
            build_model();
            run_pass(1, t[0]);
        end

        // Reset asserted during FILL
        for (int i = 0; i < 32; i++) img[i] = (i >= 28) ? 16'hFFFF : 16'h1234;
        build_model();
        load_img();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int k = 0; k < 34; k++) tick();
        chk("pre_reset_busy", {31'd0, busy_o}, 32'd1);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        chk("mid_rst_busy", {31'd0, busy_o}, 32'd0);
        chk("mid_rst_done", {31'd0, done_o}, 32'd0);
        chk("mid_rst_lines", {26'd0, lines_cleared_o}, 32'd0);
        chk("mid_rst_waddr", {27'd0, write_addr_o}, 32'd31);
        exp_q.delete();
        tick();
        chk("post_rst_idle", {31'd0, busy_o}, 32'd0);
        chk("post_rst_vw", {31'd0, v_w_o}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
